// File: rtl/serial_sub_pkg.sv
// Shared FSM state type and default operand width for the bit-serial subtractor.
// No logic; no latency; no flow control.
// No handshake of its own; consumed by serial_subtractor.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout when the bit underflows.
// Purely combinational, zero latency.
// No flow control.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first; SERIAL_SUB_OVERFLOW_EN adds the Ovf output.
// Latency: out_valid rises WIDTH cycles after the accept edge.
// Holds the result until out_ready; in_ready only in IDLE, so inputs in SHIFT/HOLD are ignored.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int                CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               borrow_q;
    logic               d_bit;
    logic               b_bit;

    // Operands shift right so the cell always sees bit[cnt] at position 0.
    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (b_bit)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            borrow_q  <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            Ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        borrow_q <= Bin;
                        cnt      <= '0;
                        Diff     <= '0;
                        Bout     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        Ovf      <= 1'b0;
`endif
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    borrow_q <= b_bit;
                    Diff     <= {d_bit, Diff[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        Bout      <= b_bit;
                        out_valid <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // On the last bit the cell inputs are the operand MSBs.
                        Ovf       <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
`endif
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor against a transaction-level model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Diff;
    logic         Bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         Ovf;
`endif

    int checks = 0;
    int failures = 0;
    bit model_on = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy for WIDTH cycles after accept, then holds result until out_ready.
    bit           m_busy = 1'b0;
    bit           m_valid = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_diff;
    logic         p_bout;
    logic         p_ovf;

    always @(posedge clk) begin
        int d;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_left = 0;
            m_diff = '0; m_bout = 0; m_ovf = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                d      = int'(A) - int'(B) - int'(Bin);
                p_diff = d[W-1:0];
                p_bout = (d < 0);
                p_ovf  = (A[W-1] != B[W-1]) && (p_diff[W-1] != A[W-1]);
                m_busy = 1; m_left = W;
                m_diff = '0; m_bout = 0; m_ovf = 0;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1; m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
            end
        end else if (out_ready) begin
            m_valid = 0; m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid || !m_busy) begin
                check("diff", {28'd0, Diff}, {28'd0, m_diff});
                check("bout", {31'd0, Bout}, {31'd0, m_bout});
`ifdef SERIAL_SUB_OVERFLOW_EN
                check("ovf", {31'd0, Ovf}, {31'd0, m_ovf});
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int hold, input bit poke,
                          output logic [W-1:0] rd, output logic rb, output logic ro);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            if (poke) begin
                in_valid = (lat == 1); A = 1; B = 1; Bin = 1'b0;
            end else begin
                in_valid = 1'($urandom); A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, W);
        rd = Diff; rb = Bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ro = Ovf;
`else
        ro = 1'b0;
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); A = W'($urandom); B = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic rb, ro;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        model_on = 1'b1;
        check("rst_diff", {28'd0, Diff}, 0);
        check("rst_bout", {31'd0, Bout}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 1);

        run_op(4'd9, 4'd3, 1'b0, 0, 1'b0, rd, rb, ro);
        check("9-3_diff", {28'd0, rd}, 32'h6);
        check("9-3_bout", {31'd0, rb}, 0);
        run_op(4'd3, 4'd9, 1'b0, 1, 1'b0, rd, rb, ro);
        check("3-9_diff", {28'd0, rd}, 32'hA);
        check("3-9_bout", {31'd0, rb}, 1);
        run_op(4'd0, 4'd0, 1'b1, 0, 1'b0, rd, rb, ro);
        check("0-0-1_diff", {28'd0, rd}, 32'hF);
        check("0-0-1_bout", {31'd0, rb}, 1);
        run_op(4'd9, 4'd3, 1'b0, 3, 1'b0, rd, rb, ro);
        check("hold3_diff", {28'd0, rd}, 32'h6);
        run_op(4'd9, 4'd3, 1'b0, 0, 1'b1, rd, rb, ro);
        check("poke_diff", {28'd0, rd}, 32'h6);
        check("poke_bout", {31'd0, rb}, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op(4'd7, 4'hF, 1'b0, 0, 1'b0, rd, rb, ro);
        check("ovf_diff", {28'd0, rd}, 32'h8);
        check("ovf_flag", {31'd0, ro}, 1);
        check("ovf_bout", {31'd0, rb}, 1);
        run_op(4'd5, 4'd2, 1'b0, 0, 1'b0, rd, rb, ro);
        check("noovf_flag", {31'd0, ro}, 0);
`endif

        // Abort mid-operation with reset.
        A = 4'd9; B = 4'd3; Bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_diff", {28'd0, Diff}, 0);
        check("abort_out_valid", {31'd0, out_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 1);
        n = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("abort_no_pulse", n, 0);

        for (int t = 0; t < 200; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0, rd, rb, ro);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001: Parameter WIDTH SHALL default to 4 and set the operand/result width in bits; legal range 2..32.
REQ-002: Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003: Port rst SHALL be an input, 1 bit, with synchronous, active-high reset.
REQ-004: Port in_valid SHALL be an input, 1 bit, indicating that an operand set is presented.
REQ-005: Port in_ready SHALL be an output, 1 bit, indicating that the block accepts operands (state IDLE).
REQ-006: Ports A and B SHALL be inputs, WIDTH bits each, holding the minuend and subtrahend.
REQ-007: Port Bin SHALL be an input, 1 bit, the borrow-in.
REQ-008: Port out_valid SHALL be an output, 1 bit, indicating that the result is valid.
REQ-009: Port out_ready SHALL be an input, 1 bit, indicating that the consumer accepts the result.
REQ-010: Port Diff SHALL be an output, WIDTH bits, carrying the difference.
REQ-011: Port Bout SHALL be an output, 1 bit, carrying the borrow-out.

Function
REQ-012: Arithmetic SHALL be Diff = (A - B - Bin) mod 2^WIDTH, with Bout = 1 exactly when A < B + Bin (unsigned).
REQ-013: The computation SHALL be bit-serial ripple-borrow: one bit per cycle, LSB first, with the borrow held in a 1-bit register between bits.
REQ-014: The FSM SHALL have three states: IDLE, SHIFT and HOLD.
REQ-015: In IDLE, in_ready SHALL be 1; when in_valid && in_ready, the block SHALL capture A, B and Bin, clear the bit counter and go to SHIFT.
REQ-016: In SHIFT, each cycle SHALL compute bit[cnt] and increment cnt; after bit WIDTH-1 the FSM SHALL go to HOLD.
REQ-017: Latency SHALL be WIDTH cycles, with out_valid rising exactly WIDTH cycles after the accept edge.
REQ-018: In HOLD, out_valid SHALL be 1 and Diff/Bout stable; when out_ready is 1, the FSM SHALL return to IDLE on that edge.
REQ-019: out_valid && out_ready in HOLD SHALL complete the transfer; the next accept SHALL be possible no earlier than the following cycle (in_ready is 0 in HOLD).
REQ-020: in_valid asserted in SHIFT or HOLD SHALL be ignored, and captured operands SHALL remain unaffected by input changes after the accept.
REQ-021: Diff and Bout SHALL hold the last result until the next accept; at the next accept they SHALL clear to 0.
REQ-022: The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-023: When rst is 1, the block SHALL force state IDLE, cnt 0, Diff 0, Bout 0, out_valid 0 and the borrow register 0.
REQ-024: rst SHALL take priority over in_valid and out_ready in the same cycle.
REQ-025: Reset during SHIFT or HOLD SHALL abort the operation, with no out_valid pulse afterwards.
REQ-026: in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027: With macro SERIAL_SUB_OVERFLOW_EN defined, the block SHALL add output Ovf (1 bit, reset 0) with Ovf = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]), valid with out_valid (two's-complement overflow).
REQ-028: Without SERIAL_SUB_OVERFLOW_EN, the Ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029: Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/HOLD) and the default WIDTH constant.
REQ-030: Sub-module full_subtractor (a, b, bin -> d, bout) SHALL implement the per-bit cell, instantiated once and reused serially.

Verification (WIDTH=4)
REQ-031: A=9, B=3, Bin=0 accepted -> after 4 cycles, out_valid=1, Diff=6, Bout=0.
REQ-032: A=3, B=9, Bin=0 -> Diff=0xA, Bout=1; A=0, B=0, Bin=1 -> Diff=0xF, Bout=1.
REQ-033: out_ready held 0 for 3 cycles in HOLD -> out_valid, Diff and Bout stay stable; completion on the first out_ready=1 edge; in_ready=1 the next cycle.
REQ-034: in_valid pulsed with A=1, B=1 during SHIFT of 9-3 -> result still Diff=6, and the second operand set is not captured.
REQ-035: rst asserted at SHIFT cycle 2 -> next cycle IDLE, Diff=0, out_valid stays 0, in_ready=1 after rst deasserts.
REQ-036: With SERIAL_SUB_OVERFLOW_EN, A=7, B=0xF, Bin=0 -> Diff=0x8, Ovf=1, Bout=1; A=5, B=2 -> Ovf=0.
